mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum WAIT-state cycles before an access is aborted, range 1..255.
REQ-002 clk_i  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 ALUresult_i  input  32  from EX/MEM latch; memory byte address, or the writeback value for non-load instructions.
REQ-005 RS2data_i  input  32  store data.
REQ-006 RDaddr_i  input  5  destination register.
REQ-007 MemRead_i, MemWrite_i, MemtoReg_i, RegWrite_i  input  1 each  pipeline control.
REQ-008 dmem_req_o  output  1  memory request, level, held until ack or abort.
REQ-009 dmem_we_o  output  1  1 = store.
REQ-010 dmem_addr_o, dmem_wdata_o  output  32 each  registered address and store data.
REQ-011 dmem_ack_i  input  1  one-cycle completion strobe.
REQ-012 dmem_rdata_i  input  32  load data, valid in the ack cycle.
REQ-013 stall_o  output  1  freezes the EX/MEM latch and all upstream stages.
REQ-014 RDdata_o  output  32, RDaddr_o  output  5, RegWrite_o  output  1  registered MEM/WB outputs.
REQ-015 err_o  output  1  sticky access-timeout flag.
REQ-016 misalign_o  output  1  one-cycle misaligned-access pulse (see Configuration).

Function
REQ-017 The FSM SHALL have two states: IDLE and WAIT.
REQ-018 IDLE with MemRead_i|MemWrite_i SHALL register the address, data and write enable, then enter WAIT; stall_o=1 in that cycle.
REQ-019 In WAIT, dmem_req_o=1; dmem_addr_o, dmem_wdata_o and dmem_we_o SHALL stay constant.
REQ-020 stall_o SHALL equal (IDLE & access) | (WAIT & ~dmem_ack_i & ~timeout), combinationally.
REQ-021 In WAIT, dmem_ack_i SHALL return the FSM to IDLE, and stall_o=0 in that cycle.
REQ-022 A WAIT cycle counter SHALL reach TIMEOUT_CYCLES, then abort: set err_o, deassert req, return to IDLE, stall_o=0, and write RegWrite_o=0 for that instruction.
REQ-023 If ack and timeout occur in the same cycle, ack SHALL take priority and no error is raised.
REQ-024 dmem_ack_i in IDLE SHALL be ignored.
REQ-025 If MemRead_i and MemWrite_i are both 1, the access SHALL be treated as a store (dmem_we_o=1).
REQ-026 On every edge with stall_o=0, the MEM/WB outputs SHALL load: RDaddr_o<=RDaddr_i, RegWrite_o<=RegWrite_i, RDdata_o<=(MemtoReg_i ? dmem_rdata_i : ALUresult_i).
REQ-027 On every edge with stall_o=1, RegWrite_o SHALL be 0 (bubble), and RDdata_o and RDaddr_o SHALL be held.
REQ-028 Latency: an ack in the k-th WAIT cycle SHALL give k stall cycles, with the result visible one edge after the ack.
REQ-029 Non-memory instructions SHALL pass with 1-cycle latency and no stall.

Reset
REQ-030 When rst_i is sampled high, the block SHALL go to IDLE and clear the counter to 0.
REQ-031 Reset SHALL zero dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, RDdata_o, RDaddr_o, RegWrite_o, err_o and misalign_o.
REQ-032 Reset in WAIT SHALL drop dmem_req_o on the next edge.
REQ-033 A late ack after a reset SHALL be ignored.

Configuration
REQ-034 With MEM_ALIGN_CHECK_EN defined, an access with ALUresult_i[1:0]!=0 SHALL not be issued: misalign_o pulses 1 for one cycle, no stall occurs, and RegWrite_o=0 for that instruction.
REQ-035 Without MEM_ALIGN_CHECK_EN, the address SHALL pass unchecked and misalign_o SHALL be tied 0.

Verification
REQ-036 ALU op (RegWrite=1, RDaddr=5, ALUresult=0x1234) -> next cycle RDdata_o=0x1234, RDaddr_o=5, RegWrite_o=1, stall_o never 1.
REQ-037 Load from addr 0x40, ack after 3 WAIT cycles with rdata 0xDEADBEEF -> stall_o high 3 cycles, req/addr stable, then RDdata_o=0xDEADBEEF, RegWrite_o=1.
REQ-038 Store addr 0x80 data 0xA5A5A5A5, ack in first WAIT cycle -> dmem_we_o=1, exactly 1 stall cycle, RegWrite_o=0 bubble then instruction's RegWrite.
REQ-039 Load with TIMEOUT_CYCLES=4 and no ack -> req drops after 4 WAIT cycles, err_o=1 sticky, RegWrite_o=0; ack on the timeout cycle -> err_o stays 0.
REQ-040 rst_i asserted during WAIT -> next edge req=0, all outputs 0; a subsequent stray ack causes no write.
REQ-041 MEM_ALIGN_CHECK_EN defined, load addr 0x42 -> misalign_o one-cycle pulse, no req, no stall, RegWrite_o=0.

Source files
------------

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : MEM stage of a 5-stage pipeline. Issues one data-memory access
//            per load/store over a level req / one-cycle ack handshake,
//            stalls the pipeline while the access is outstanding, aborts an
//            access that waits too long, and registers the MEM/WB results.
// Revision : 1.0 - initial release
//
// Parameters
//   TIMEOUT_CYCLES  WAIT-state cycles allowed before an access is aborted
//                   (1..255)
//
// Optional feature
//   MEM_ALIGN_CHECK_EN  when defined, a load/store whose address has
//                       ALUresult_i[1:0] != 0 is not issued; misalign_o
//                       pulses and the instruction is squashed. When
//                       undefined, addresses pass unchecked and misalign_o
//                       is tied 0.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   ALUresult_i             byte address or non-load writeback value
//   RS2data_i               store data
//   RDaddr_i                destination register
//   MemRead_i, MemWrite_i,
//   MemtoReg_i, RegWrite_i  pipeline control from EX/MEM
//   dmem_req_o, dmem_we_o   memory request (level) and write enable
//   dmem_addr_o,
//   dmem_wdata_o            registered address / store data
//   dmem_ack_i,
//   dmem_rdata_i            completion strobe and load data
//   stall_o                 freezes EX/MEM and upstream stages
//   RDdata_o, RDaddr_o,
//   RegWrite_o              registered MEM/WB outputs
//   err_o                   sticky access-timeout flag
//   misalign_o              one-cycle misaligned-access pulse
// ============================================================================
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ALUresult_i,
  input  logic [31:0] RS2data_i,
  input  logic [4:0]  RDaddr_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        MemtoReg_i,
  input  logic        RegWrite_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic [31:0] RDdata_o,
  output logic [4:0]  RDaddr_o,
  output logic        RegWrite_o,
  output logic        err_o,
  output logic        misalign_o
);

  // Counter value seen in the last permitted WAIT cycle.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [7:0]  wait_cnt;
  logic        mem_op;
  logic        misaligned;
  logic        issue;
  logic        misalign_drop;
  logic        timeout;
  logic        abort;

  assign mem_op = MemRead_i | MemWrite_i;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = mem_op & (ALUresult_i[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign issue         = mem_op & ~misaligned;
  // Misalignment can only be detected when a new instruction is presented;
  // in WAIT the EX/MEM latch is frozen on an already-accepted access.
  assign misalign_drop = (state == S_IDLE) & misaligned;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and stall. Ack wins over timeout in the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    stall_o    = 1'b0;
    timeout    = 1'b0;
    abort      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (issue) begin
          stall_o    = 1'b1;
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        timeout = (wait_cnt == TMO_LAST);
        if (dmem_ack_i) begin
          next_state = S_IDLE;
        end else if (timeout) begin
          abort      = 1'b1;
          next_state = S_IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign dmem_req_o = (state == S_WAIT);

  // Counts WAIT cycles; zero on the first WAIT cycle of every access.
  always_ff @(posedge clk_i) begin
    if (rst_i || state != S_WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Request registers: captured once on issue, stable for the whole access.
  // A simultaneous read+write is treated as a store.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      dmem_we_o    <= 1'b0;
    end else if (state == S_IDLE && issue) begin
      dmem_addr_o  <= ALUresult_i;
      dmem_wdata_o <= RS2data_i;
      dmem_we_o    <= MemWrite_i;
    end
  end

  // Sticky timeout flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (abort) begin
      err_o <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // MEM/WB register. A stalled edge inserts a bubble and holds data; an
  // aborted or misaligned instruction advances but never writes back.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      RDdata_o   <= '0;
      RDaddr_o   <= '0;
      RegWrite_o <= 1'b0;
    end else if (stall_o) begin
      RegWrite_o <= 1'b0;
    end else begin
      RDaddr_o   <= RDaddr_i;
      RDdata_o   <= MemtoReg_i ? dmem_rdata_i : ALUresult_i;
      RegWrite_o <= RegWrite_i & ~abort & ~misalign_drop;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= misalign_drop;
    end
  end
`else
  assign misalign_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Purpose  : Self-checking bench for mem_access_stage. Each instruction is
//            described as a transaction (operands, control, cycle of the ack)
//            and its expected stall profile and writeback are derived from
//            the stage's behavioural rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  localparam int TMO = 4;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] ALUresult_i = '0;
  logic [31:0] RS2data_i = '0;
  logic [4:0]  RDaddr_i = '0;
  logic        MemRead_i = 1'b0;
  logic        MemWrite_i = 1'b0;
  logic        MemtoReg_i = 1'b0;
  logic        RegWrite_i = 1'b0;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        stall_o;
  logic [31:0] RDdata_o;
  logic [4:0]  RDaddr_o;
  logic        RegWrite_o;
  logic        err_o;
  logic        misalign_o;

  mem_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .ALUresult_i  (ALUresult_i),
    .RS2data_i    (RS2data_i),
    .RDaddr_i     (RDaddr_i),
    .MemRead_i    (MemRead_i),
    .MemWrite_i   (MemWrite_i),
    .MemtoReg_i   (MemtoReg_i),
    .RegWrite_i   (RegWrite_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .stall_o      (stall_o),
    .RDdata_o     (RDdata_o),
    .RDaddr_o     (RDaddr_o),
    .RegWrite_o   (RegWrite_o),
    .err_o        (err_o),
    .misalign_o   (misalign_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: what the MEM/WB register and error flag should hold.
  logic [4:0]  m_rdaddr = '0;
  logic [31:0] m_rddata = '0;
  bit          m_rddata_known = 1'b1;
  logic        m_rw = 1'b0;
  logic        m_err = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero();
    check_val("rst_req",      32'(dmem_req_o),   32'd0);
    check_val("rst_we",       32'(dmem_we_o),    32'd0);
    check_val("rst_addr",     dmem_addr_o,       32'd0);
    check_val("rst_wdata",    dmem_wdata_o,      32'd0);
    check_val("rst_rddata",   RDdata_o,          32'd0);
    check_val("rst_rdaddr",   32'(RDaddr_o),     32'd0);
    check_val("rst_regwrite", 32'(RegWrite_o),   32'd0);
    check_val("rst_err",      32'(err_o),        32'd0);
    check_val("rst_misalign", 32'(misalign_o),   32'd0);
  endtask

  // Present one instruction starting at a falling edge and follow it until
  // it leaves the stage. ack_k = WAIT cycle in which the ack is returned;
  // any value above TMO means the memory never answers.
  task automatic run_instr(input logic [31:0] alu, input logic [31:0] rs2,
                           input logic [4:0] rd, input logic mr, input logic mw,
                           input logic m2r, input logic rw, input int ack_k,
                           input logic [31:0] rdv);
    bit is_mem;
    bit misal;
    bit done;
    bit timed_out;
    is_mem    = mr | mw;
    misal     = ALIGN_EN && is_mem && (alu[1:0] != 2'b00);
    timed_out = 1'b0;
    done      = 1'b0;
    ALUresult_i  = alu;
    RS2data_i    = rs2;
    RDaddr_i     = rd;
    MemRead_i    = mr;
    MemWrite_i   = mw;
    MemtoReg_i   = m2r;
    RegWrite_i   = rw;
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = rdv;
    #1;
    check_val("idle_req", 32'(dmem_req_o), 32'd0);
    if (is_mem && !misal) begin
      check_val("idle_stall", 32'(stall_o), 32'd1);
      for (int j = 1; j <= TMO && !done; j++) begin
        @(negedge clk);
        dmem_ack_i = (j == ack_k);
        #1;
        check_val("wait_req",    32'(dmem_req_o), 32'd1);
        check_val("wait_addr",   dmem_addr_o,     alu);
        check_val("wait_wdata",  dmem_wdata_o,    rs2);
        check_val("wait_we",     32'(dmem_we_o),  32'(mw));
        check_val("bubble_rw",   32'(RegWrite_o), 32'd0);
        check_val("held_rdaddr", 32'(RDaddr_o),   32'(m_rdaddr));
        if (m_rddata_known) check_val("held_rddata", RDdata_o, m_rddata);
        if (j == ack_k) begin
          done = 1'b1;
        end else if (j == TMO) begin
          done      = 1'b1;
          timed_out = 1'b1;
        end
        check_val("wait_stall", 32'(stall_o), 32'(!done));
      end
    end else begin
      check_val("pass_stall", 32'(stall_o), 32'd0);
    end
    @(negedge clk);
    // Expected state after the instruction leaves the stage.
    m_rdaddr       = rd;
    m_rddata       = m2r ? rdv : alu;
    m_rddata_known = !timed_out;
    m_rw           = rw && !timed_out && !misal;
    if (timed_out) m_err = 1'b1;
    dmem_ack_i = 1'b0;
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    RegWrite_i = 1'b0;
    check_val("wb_regwrite", 32'(RegWrite_o), 32'(m_rw));
    check_val("wb_rdaddr",   32'(RDaddr_o),   32'(m_rdaddr));
    if (m_rddata_known) check_val("wb_rddata", RDdata_o, m_rddata);
    check_val("err",         32'(err_o),      32'(m_err));
    check_val("misalign",    32'(misalign_o), 32'(misal));
    check_val("done_req",    32'(dmem_req_o), 32'd0);
  endtask

  logic [31:0] r_alu;
  logic [31:0] r_rs2;
  logic [31:0] r_rdv;
  logic [4:0]  r_rd;
  logic        r_mr;
  logic        r_mw;
  logic        r_m2r;
  logic        r_rw;
  int          r_kind;
  int          r_ack;

  initial begin
    // Reset
    rst_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_all_zero();
    rst_i = 1'b0;

    // ALU op passes in one cycle without stalling
    run_instr(32'h0000_1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h0);
    // Load 0x40, ack in third WAIT cycle
    run_instr(32'h0000_0040, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 3, 32'hDEAD_BEEF);
    // Store 0x80, ack in first WAIT cycle
    run_instr(32'h0000_0080, 32'hA5A5_A5A5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 32'h0);
    // Read and write together behave as a store
    run_instr(32'h0000_0100, 32'h1357_9BDF, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 2, 32'h0);
    // Ack coincides with the last allowed WAIT cycle: no error
    run_instr(32'h0000_0044, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, TMO, 32'hCAFE_F00D);
    // No ack: abort after TMO WAIT cycles, sticky error, no writeback
    run_instr(32'h0000_0048, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, TMO + 1, 32'h0);
    // Unaligned load: squashed when alignment checking is built in
    run_instr(32'h0000_0042, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 2, 32'h7777_1111);
    // Following ALU op clears the misalign pulse
    run_instr(32'h0000_5555, 32'h0, 5'd11, 1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h0);

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      r_kind = $urandom_range(0, 2);
      r_alu  = $urandom;
      r_rs2  = $urandom;
      r_rdv  = $urandom;
      r_rd   = 5'($urandom_range(0, 31));
      r_ack  = $urandom_range(1, TMO + 1);
      case (r_kind)
        0: begin r_mr = 1'b0; r_mw = 1'b0; r_m2r = 1'b0; r_rw = 1'($urandom_range(0, 1)); end
        1: begin r_mr = 1'b1; r_mw = ($urandom_range(0, 7) == 0); r_m2r = 1'b1; r_rw = 1'b1; end
        default: begin r_mr = 1'b0; r_mw = 1'b1; r_m2r = 1'b0; r_rw = 1'($urandom_range(0, 1)); end
      endcase
      if (r_kind != 0 && $urandom_range(0, 3) != 0) r_alu[1:0] = 2'b00;
      run_instr(r_alu, r_rs2, r_rd, r_mr, r_mw, r_m2r, r_rw, r_ack, r_rdv);
    end

    // Reset in the middle of an outstanding load, then a stray ack
    ALUresult_i = 32'h0000_0100;
    RDaddr_i    = 5'd9;
    MemRead_i   = 1'b1;
    MemtoReg_i  = 1'b1;
    RegWrite_i  = 1'b1;
    dmem_ack_i  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("pre_rst_req", 32'(dmem_req_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    check_all_zero();
    rst_i       = 1'b0;
    ALUresult_i = '0;
    RS2data_i   = '0;
    RDaddr_i    = '0;
    MemRead_i   = 1'b0;
    MemWrite_i  = 1'b0;
    MemtoReg_i  = 1'b0;
    RegWrite_i  = 1'b0;
    dmem_ack_i  = 1'b1;
    dmem_rdata_i = $urandom;
    #1;
    check_val("stray_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    dmem_ack_i = 1'b0;
    check_val("stray_regwrite", 32'(RegWrite_o), 32'd0);
    check_val("stray_req",      32'(dmem_req_o), 32'd0);
    check_val("stray_err",      32'(err_o),      32'd0);
    m_rdaddr = '0; m_rddata = '0; m_rddata_known = 1'b1; m_rw = 1'b0; m_err = 1'b0;

    // A clean access after reset still works
    run_instr(32'h0000_0200, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 2, 32'h0BAD_CAFE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
